prio_arb_n: RTL and testbench
=============================

# prio_arb_n

Parametrised, registered priority encoder/arbiter for N request lines. It captures requests into a sticky pending vector and offers one index at a time on a valid/ready output, in fixed-priority (highest index wins) or round-robin mode. It sits between request sources (buttons, interrupt flags, FIFO-not-empty lines) and a single consumer that services one index per handshake.

## Interface
- N, 8, number of request lines, legal 2..32
- W, $clog2(N), index width, derived and never overridden
- MODE, 0, 0 = fixed priority (highest index first), 1 = round-robin
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  N  request levels, sampled every edge, OR-ed into pending
- out_ready  in  1  consumer accepts out_idx this cycle
- out_valid  out  1  out_idx is a live offer
- out_idx  out  W  offered request index
- pending  out  N  registered sticky request vector
- busy  out  1  |pending, combinational from the register

## Operation
- Handshake: hs = out_valid & out_ready. acc_mask = hs ? onehot(out_idx) : 0.
- pending_next = (pending & ~acc_mask) | req. The offered bit stays set until accepted. A req bit high in the acceptance cycle re-sets it, as a new request.
- States: IDLE (out_valid=0) and OFFER (out_valid=1).
  - IDLE: if |pending_next, load out_idx = select(pending_next) and go to OFFER. Otherwise stay.
  - OFFER with ~out_ready: hold out_idx and out_valid unchanged, with no re-arbitration even if a higher request arrives.
  - OFFER with out_ready: if |pending_next, load the new select(pending_next) and stay in OFFER (back-to-back). Otherwise go to IDLE.
- Fixed selection: the highest set index of the vector.
- Round-robin selection:
  - ptr register holds the last accepted index. ptr_eff = hs ? out_idx : ptr.
  - The search order is ptr_eff-1, ptr_eff-2, …, 0, N-1, …, ptr_eff, with wrap-around modulo N. The first set bit wins.
  - ptr updates to out_idx on hs only.
- In fixed mode, ptr is unused and optimised away.
- Indices are always < N. out_idx is never driven with a value whose pending bit is 0 while out_valid=1.

## Timing
- Reset values: out_valid=0, out_idx=0, pending=0, busy=0, ptr=0.
- Reset is asynchronous. Asserting rst clears all registers immediately, mid-offer included. After release there is no offer until a req is sampled.
- Latency: req high at edge k (IDLE) gives out_valid=1 with out_idx valid after edge k.
- Throughput: one accepted index per cycle while out_ready=1 and requests remain.
- out_valid never drops without hs, except on reset.
- Simultaneous events:
  - Acceptance plus new req on other bits: both are considered in the same pending_next.
  - Acceptance plus req on the same bit: the bit remains pending and is eligible immediately.
- Empty: out_valid falls the edge after the last acceptance if pending_next=0.

## Structure
- Package prio_pkg holds MODE_FIXED=0, MODE_RR=1, and the state enum {ST_IDLE, ST_OFFER}.
- Sub-module prio_enc_n is a combinational N-input highest-index priority encoder with valid (d, q, v).
  - Instance 1 encodes pending_next for fixed mode and the unmasked RR fallback.
  - Instance 2 encodes pending_next masked to indices < ptr_eff.
  - RR picks instance 2 when its v=1, else instance 1.
- The top module contains the pending/ptr/out registers and the FSM.

## Test plan
- Reset: pulse rst mid-stream. out_valid=0, out_idx=0, pending=0, busy=0 before the next edge.
- Fixed, N=8: req=8'b0010_0110 for one cycle, out_ready=1. out_idx sequence is 5, 2, 1 on consecutive cycles, then out_valid=0 and busy=0.
- Stall: req=8'h81 for one cycle, out_ready=0 for 3 cycles.
  - out_idx=7 is held and pending=8'h81.
  - Raising req[7]'s neighbour bit 6 during the stall does not change out_idx.
  - After out_ready=1, the sequence is 7, 6, 0.
- Round-robin vs fixed: req=8'h0C held high, out_ready=1.
  - MODE=1 gives 3, 2, 3, 2, …
  - MODE=0 gives 3, 3, 3, …
- Same-bit re-request: accept idx 3 while req[3]=1. pending[3] stays 1 and out_valid stays 1.
- Wrap-around: MODE=1, accept idx 0, then req=8'h81. The next offer is 7, then 0.

Source files
------------

// File: rtl/prio_pkg.sv
// prio_pkg: shared definitions for the prio_arb_n request arbiter.
//   MODE_FIXED / MODE_RR : selection policy values for the MODE parameter.
//   state_e              : offer FSM state (idle / offering an index).
package prio_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_e;

endpackage

// File: rtl/prio_enc_n.sv
// prio_enc_n: combinational N-input priority encoder, highest set index wins.
// Ports:
//   d : N-bit input vector
//   q : index of the highest set bit of d (0 when d is all zero)
//   v : 1 when any bit of d is set
module prio_enc_n #(
    parameter int N = 8
) (
    input  logic [N-1:0]         d,
    output logic [$clog2(N)-1:0] q,
    output logic                 v
);

    localparam int W = $clog2(N);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        q = '0;
        v = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (d[i]) begin
                q = W'(i);
                v = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_arb_n.sv
// prio_arb_n: registered priority arbiter for N sticky request lines.
// Requests are OR-ed into a pending vector; one pending index at a time is
// offered on a valid/ready output, chosen by fixed priority (highest index)
// or round-robin (search downward from the last accepted index, wrapping).
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   req        : request levels, sampled every edge
//   out_ready  : consumer accepts out_idx this cycle
//   out_valid  : out_idx is a live offer
//   out_idx    : offered request index
//   pending    : registered sticky request vector
//   busy       : |pending
//   dbg_state  : current offer FSM state
//
// Handshake: a transfer happens on every rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the offer (valid and
// index) is frozen; out_valid only falls after a transfer (or on reset).
module prio_arb_n
    import prio_pkg::*;
#(
    parameter int N    = 8,
    parameter int MODE = MODE_FIXED
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] out_idx,
    output logic [N-1:0]         pending,
    output logic                 busy,
    output state_e               dbg_state
);

    localparam int W = $clog2(N);

    state_e         state, state_next;
    logic [W-1:0]   idx_q, idx_next;
    logic [N-1:0]   pend_q;
    logic [N-1:0]   acc_mask;
    logic [N-1:0]   pending_next;
    logic           hs;
    logic [W-1:0]   q_all;
    logic           v_all;
    logic [W-1:0]   sel_idx;

    assign hs = (state == ST_OFFER) && out_ready;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            acc_mask[i] = hs && (idx_q == W'(i));
        end
    end

    // A req bit high in the acceptance cycle re-sets the accepted bit.
    assign pending_next = (pend_q & ~acc_mask) | req;

    prio_enc_n #(.N(N)) u_enc_all (
        .d (pending_next),
        .q (q_all),
        .v (v_all)
    );

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [W-1:0] ptr;
            logic [W-1:0] ptr_eff;
            logic [N-1:0] lo_mask;
            logic [W-1:0] q_lo;
            logic         v_lo;

            // The index being accepted this cycle already counts as the last
            // served one, so back-to-back offers rotate without a bubble.
            assign ptr_eff = hs ? idx_q : ptr;

            always_comb begin
                for (int i = 0; i < N; i++) begin
                    lo_mask[i] = (i < int'(ptr_eff));
                end
            end

            // Highest set index below ptr_eff is the first hit of the
            // downward search; if none, the unmasked highest index is the
            // first hit after wrapping from N-1.
            prio_enc_n #(.N(N)) u_enc_lo (
                .d (pending_next & lo_mask),
                .q (q_lo),
                .v (v_lo)
            );

            assign sel_idx = v_lo ? q_lo : q_all;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ptr <= '0;
                end else if (hs) begin
                    ptr <= idx_q;
                end
            end
        end else begin : g_fixed
            assign sel_idx = q_all;
        end
    endgenerate

    // State register (with pending vector and offered index).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx_q  <= '0;
            pend_q <= '0;
        end else begin
            state  <= state_next;
            idx_q  <= idx_next;
            pend_q <= pending_next;
        end
    end

    // Next-state logic. A stalled offer is never re-arbitrated.
    always_comb begin
        state_next = state;
        idx_next   = idx_q;
        case (state)
            ST_IDLE: begin
                if (v_all) begin
                    state_next = ST_OFFER;
                    idx_next   = sel_idx;
                end
            end
            ST_OFFER: begin
                if (out_ready) begin
                    if (v_all) begin
                        idx_next = sel_idx;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        out_valid = (state == ST_OFFER);
        out_idx   = idx_q;
        pending   = pend_q;
        busy      = |pend_q;
        dbg_state = state;
    end

endmodule

// File: tb/tb_prio_arb_n.sv
module tb_prio_arb_n;
    import prio_pkg::*;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         out_ready;

    // Index 0 = fixed-priority instance, index 1 = round-robin instance.
    logic         valid_v   [2];
    logic [W-1:0] idx_v     [2];
    logic [N-1:0] pend_v    [2];
    logic         busy_v    [2];
    state_e       st_v      [2];

    int checks;
    int failures;

    // Reference model state.
    logic [N-1:0] m_pend  [2];
    logic         m_valid [2];
    int           m_idx   [2];
    int           m_ptr   [2];

    prio_arb_n #(.N(N), .MODE(MODE_FIXED)) dut_fx (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (valid_v[0]),
        .out_idx   (idx_v[0]),
        .pending   (pend_v[0]),
        .busy      (busy_v[0]),
        .dbg_state (st_v[0])
    );

    prio_arb_n #(.N(N), .MODE(MODE_RR)) dut_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (valid_v[1]),
        .out_idx   (idx_v[1]),
        .pending   (pend_v[1]),
        .busy      (busy_v[1]),
        .dbg_state (st_v[1])
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Selection straight from the rules: fixed = highest set index,
    // round-robin = first set bit in order peff-1, peff-2, ... modulo N.
    function automatic int pick(input int m, input logic [N-1:0] v, input int peff);
        if (m == 0) begin
            for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (peff - k + N) % N;
                if (v[j]) return j;
            end
        end
        return 0;
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            m_pend[m]  = '0;
            m_valid[m] = 1'b0;
            m_idx[m]   = 0;
            m_ptr[m]   = 0;
        end
    endtask

    // Advances the model by one edge using the inputs currently driven.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            logic         hs;
            logic [N-1:0] pn;
            int           peff;
            hs = m_valid[m] && out_ready;
            pn = m_pend[m];
            if (hs) pn[m_idx[m]] = 1'b0;
            pn = pn | req;
            peff = hs ? m_idx[m] : m_ptr[m];
            if (hs) m_ptr[m] = m_idx[m];
            if (!m_valid[m] || out_ready) begin
                if (pn != '0) begin
                    m_valid[m] = 1'b1;
                    m_idx[m]   = pick(m, pn, peff);
                end else begin
                    m_valid[m] = 1'b0;
                end
            end
            m_pend[m] = pn;
        end
    endtask

    // Driver: apply inputs, advance model, step one clock, sample at edge+1.
    task automatic cycle(input logic [N-1:0] r, input logic rdy);
        req       = r;
        out_ready = rdy;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req       = '0;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        // Initial reset.
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (valid_v[m] !== 1'b0 || idx_v[m] !== '0 || pend_v[m] !== '0 ||
                busy_v[m] !== 1'b0 || st_v[m] !== ST_IDLE) begin
                failures++;
                $display("FAIL reset_init m=%0d: valid=%b idx=%0d pend=%h busy=%b, want 0 0 00 0",
                         m, valid_v[m], idx_v[m], pend_v[m], busy_v[m]);
            end
        end
        do_reset();
        // Mid-offer asynchronous reset, checked before the next edge.
        cycle(8'hFF, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (valid_v[m] !== 1'b0 || idx_v[m] !== '0 || pend_v[m] !== '0 || busy_v[m] !== 1'b0) begin
                failures++;
                $display("FAIL reset_async m=%0d: valid=%b idx=%0d pend=%h busy=%b, want 0 0 00 0",
                         m, valid_v[m], idx_v[m], pend_v[m], busy_v[m]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        cycle('0, 1'b1);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (valid_v[m] !== 1'b0 || busy_v[m] !== 1'b0) begin
                failures++;
                $display("FAIL reset_no_offer m=%0d: valid=%b busy=%b, want 0 0",
                         m, valid_v[m], busy_v[m]);
            end
        end
    endtask

    task automatic test_fixed_seq();
        int exp_idx [3] = '{5, 2, 1};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cycle((k == 0) ? 8'b0010_0110 : 8'h00, 1'b1);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (valid_v[m] !== 1'b1 || int'(idx_v[m]) != exp_idx[k]) begin
                    failures++;
                    $display("FAIL seq_526 m=%0d step=%0d: valid=%b idx=%0d, want 1 %0d",
                             m, k, valid_v[m], idx_v[m], exp_idx[k]);
                end
            end
        end
        cycle('0, 1'b1);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (valid_v[m] !== 1'b0 || busy_v[m] !== 1'b0) begin
                failures++;
                $display("FAIL seq_empty m=%0d: valid=%b busy=%b, want 0 0", m, valid_v[m], busy_v[m]);
            end
        end
    endtask

    task automatic test_stall();
        logic [N-1:0] stall_req  [3] = '{8'h81, 8'h00, 8'h40};
        logic [N-1:0] stall_pend [3] = '{8'h81, 8'h81, 8'hC1};
        int           exp_idx    [2] = '{6, 0};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cycle(stall_req[k], 1'b0);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (valid_v[m] !== 1'b1 || idx_v[m] !== 3'd7 || pend_v[m] !== stall_pend[k]) begin
                    failures++;
                    $display("FAIL stall_hold m=%0d step=%0d: valid=%b idx=%0d pend=%h, want 1 7 %h",
                             m, k, valid_v[m], idx_v[m], pend_v[m], stall_pend[k]);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            cycle('0, 1'b1);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (valid_v[m] !== 1'b1 || int'(idx_v[m]) != exp_idx[k]) begin
                    failures++;
                    $display("FAIL stall_drain m=%0d step=%0d: valid=%b idx=%0d, want 1 %0d",
                             m, k, valid_v[m], idx_v[m], exp_idx[k]);
                end
            end
        end
        cycle('0, 1'b1);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (valid_v[m] !== 1'b0) begin
                failures++;
                $display("FAIL stall_empty m=%0d: valid=%b, want 0", m, valid_v[m]);
            end
        end
    endtask

    task automatic test_rr_vs_fixed();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            int exp_rr;
            cycle(8'h0C, 1'b1);
            exp_rr = (k % 2 == 0) ? 3 : 2;
            checks++;
            if (valid_v[0] !== 1'b1 || idx_v[0] !== 3'd3) begin
                failures++;
                $display("FAIL fixed_0c step=%0d: valid=%b idx=%0d, want 1 3", k, valid_v[0], idx_v[0]);
            end
            checks++;
            if (valid_v[1] !== 1'b1 || int'(idx_v[1]) != exp_rr) begin
                failures++;
                $display("FAIL rr_0c step=%0d: valid=%b idx=%0d, want 1 %0d", k, valid_v[1], idx_v[1], exp_rr);
            end
        end
    endtask

    task automatic test_same_bit();
        do_reset();
        cycle(8'h08, 1'b1);
        cycle(8'h08, 1'b1);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (valid_v[m] !== 1'b1 || idx_v[m] !== 3'd3 || pend_v[m] !== 8'h08) begin
                failures++;
                $display("FAIL same_bit m=%0d: valid=%b idx=%0d pend=%h, want 1 3 08",
                         m, valid_v[m], idx_v[m], pend_v[m]);
            end
        end
        cycle('0, 1'b1);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (valid_v[m] !== 1'b0 || pend_v[m] !== 8'h00) begin
                failures++;
                $display("FAIL same_bit_drain m=%0d: valid=%b pend=%h, want 0 00", m, valid_v[m], pend_v[m]);
            end
        end
    endtask

    task automatic test_wrap();
        int exp_idx [2] = '{7, 0};
        do_reset();
        cycle(8'h01, 1'b1);
        cycle(8'h00, 1'b1);   // accepts index 0
        cycle(8'h81, 1'b1);
        checks++;
        if (valid_v[1] !== 1'b1 || int'(idx_v[1]) != exp_idx[0]) begin
            failures++;
            $display("FAIL wrap_first: valid=%b idx=%0d, want 1 7", valid_v[1], idx_v[1]);
        end
        cycle(8'h00, 1'b1);
        checks++;
        if (valid_v[1] !== 1'b1 || int'(idx_v[1]) != exp_idx[1]) begin
            failures++;
            $display("FAIL wrap_second: valid=%b idx=%0d, want 1 0", valid_v[1], idx_v[1]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] r;
            logic         rdy;
            r   = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            rdy = ($urandom_range(0, 9) < 7);
            cycle(r, rdy);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (valid_v[m] !== m_valid[m] || pend_v[m] !== m_pend[m] ||
                    busy_v[m] !== (m_pend[m] != '0) ||
                    (m_valid[m] && int'(idx_v[m]) != m_idx[m])) begin
                    failures++;
                    $display("FAIL random m=%0d cyc=%0d: valid=%b idx=%0d pend=%h busy=%b, want %b %0d %h %b",
                             m, k, valid_v[m], idx_v[m], pend_v[m], busy_v[m],
                             m_valid[m], m_idx[m], m_pend[m], (m_pend[m] != '0));
                end
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        model_clear();
        #1;
        test_reset();
        test_fixed_seq();
        test_stall();
        test_rr_vs_fixed();
        test_same_bit();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
